multicycle_ctrl: RTL and testbench

Control FSM for the multicycle RV32I datapath: one shared ALU and one unified instruction/data memory, with one instruction sequenced over 3–5 states.
- Decodes op/funct3 itself.
- Drives all enables and mux selects.
- Stalls on a memory-ready handshake.
- Flags unimplemented instructions.
- Supported ops: lw, sw, R-type, I-type ALU, beq, bne, jal.

---
 rtl/multicycle_ctrl_pkg.sv | 46 ++++
 rtl/multicycle_ctrl_if.sv | 30 +++
 rtl/multicycle_ctrl_instrdec.sv | 20 ++
 rtl/multicycle_ctrl.sv | 152 +++++++++++++++
 tb/tb_multicycle_ctrl.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and encodings for the multicycle RV32I control path.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH,
    S_JAL
  } statetype;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Datapath-facing control bundle: instruction fields and flags in, enables/selects out.
interface multicycle_ctrl_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       Zero;
  logic       MemReady;
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [1:0] ImmSrc;
  logic       Illegal;

  modport master (
    output op, funct3, Zero, MemReady,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, Illegal
  );

  modport slave (
    input  op, funct3, Zero, MemReady,
    output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, Illegal
  );
endinterface

// File: rtl/multicycle_ctrl_instrdec.sv
// Immediate-format decode from the opcode alone.
module instrdec
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0] op,
  output logic [1:0] ImmSrc
);

  // Opcodes without a dedicated format fall back to the I-type layout.
  always_comb begin
    ImmSrc = IMM_I;
    case (op)
      OP_STORE:  ImmSrc = IMM_S;
      OP_BRANCH: ImmSrc = IMM_B;
      OP_JAL:    ImmSrc = IMM_J;
      default:   ImmSrc = IMM_I;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle RV32I datapath.
//   state      | meaning
//   S_FETCH    | read instruction at PC, PC+4 -> PC when memory ready
//   S_DECODE   | register read, branch target -> ALUOut, dispatch on op
//   S_MEMADR   | rs1 + imm -> ALUOut (load/store address)
//   S_MEMREAD  | read data memory at ALUOut, wait for MemReady
//   S_MEMWB    | loaded data -> rd
//   S_MEMWRITE | write data memory at ALUOut, held until MemReady
//   S_EXECR    | rs1 op rs2
//   S_EXECI    | rs1 op imm
//   S_ALUWB    | ALUOut -> rd
//   S_BRANCH   | compare rs1/rs2, conditionally load PC from ALUOut
//   S_JAL      | OldPC + 4 -> ALUOut, jump target -> PC
module multicycle_ctrl
  import riscv_ctrl_pkg::*;
#(
  parameter statetype RESET_STATE = S_FETCH
) (
  input  logic        clk,
  input  logic        reset,
  multicycle_ctrl_if.slave bus
);

  statetype   state, next_state;
  logic       pc_update, branch, ir_write, illegal_dec;
  logic       adr_src, mem_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
  logic       take_branch;

  // State register; reset aborts whatever instruction was in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RESET_STATE;
    else       state <= next_state;
  end

  // Next-state and Moore output decode; unlisted outputs stay 0.
  always_comb begin
    next_state  = S_FETCH;
    pc_update   = 1'b0;
    branch      = 1'b0;
    ir_write    = 1'b0;
    illegal_dec = 1'b0;
    adr_src     = 1'b0;
    mem_write   = 1'b0;
    reg_write   = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    alu_op      = 2'b00;
    case (state)
      S_FETCH: begin
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_FOUR;
        alu_op     = ALUOP_ADD;
        result_src = RES_ALURESULT;
        ir_write   = bus.MemReady;
        pc_update  = bus.MemReady;
        next_state = bus.MemReady ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_ADD;
        case (bus.op)
          OP_LOAD, OP_STORE: next_state = S_MEMADR;
          OP_RTYPE:          next_state = S_EXECR;
          OP_ITYPE:          next_state = S_EXECI;
          OP_JAL:            next_state = S_JAL;
          OP_BRANCH: begin
            if (bus.funct3[2:1] == 2'b00) next_state = S_BRANCH;
            else                          illegal_dec = 1'b1;
          end
          default:           illegal_dec = 1'b1;
        endcase
      end
      S_MEMADR: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_IMM;
        alu_op     = ALUOP_ADD;
        next_state = (bus.op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr_src    = 1'b1;
        result_src = RES_ALUOUT;
        next_state = bus.MemReady ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        result_src = RES_DATA;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src    = 1'b1;
        result_src = RES_ALUOUT;
        mem_write  = 1'b1;
        next_state = bus.MemReady ? S_FETCH : S_MEMWRITE;
      end
      S_EXECR: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_RS2;
        alu_op     = ALUOP_FUNCT;
        next_state = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_IMM;
        alu_op     = ALUOP_FUNCT;
        next_state = S_ALUWB;
      end
      S_ALUWB: begin
        result_src = RES_ALUOUT;
        reg_write  = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_RS2;
        alu_op     = ALUOP_SUB;
        result_src = RES_ALUOUT;
        branch     = 1'b1;
      end
      S_JAL: begin
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        alu_op     = ALUOP_ADD;
        result_src = RES_ALUOUT;
        pc_update  = 1'b1;
        next_state = S_ALUWB;
      end
      default: next_state = S_FETCH;
    endcase
  end

  // funct3[0] selects bne (take on not-equal) versus beq.
  assign take_branch = branch & (bus.funct3[0] ? ~bus.Zero : bus.Zero);

  // Strobes are masked during reset since S_FETCH would otherwise follow MemReady.
  assign bus.PCWrite   = ~reset & (pc_update | take_branch);
  assign bus.IRWrite   = ~reset & ir_write;
  assign bus.RegWrite  = ~reset & reg_write;
  assign bus.MemWrite  = ~reset & mem_write;
  assign bus.Illegal   = ~reset & illegal_dec;
  assign bus.AdrSrc    = adr_src;
  assign bus.ResultSrc = result_src;
  assign bus.ALUSrcA   = alu_src_a;
  assign bus.ALUSrcB   = alu_src_b;
  assign bus.ALUOp     = alu_op;

  instrdec u_instrdec (
    .op     (bus.op),
    .ImmSrc (bus.ImmSrc)
  );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed-vector bench for multicycle_ctrl: every cycle's full output word is compared.
module tb_multicycle_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multicycle_ctrl_if bus ();

  multicycle_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, Illegal}
  logic [16:0] obs;
  assign obs = {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.RegWrite,
                bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.ImmSrc, bus.Illegal};

  logic [1:0] imm;

  task automatic chk(input string tag, input logic [16:0] got, input logic [16:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %05h expected %05h", tag, got, exp);
    end
  endtask

  function automatic logic [16:0] mk(input logic pc, adr, mw, ir, rw,
                                     input logic [1:0] rs, a, b, aop, im,
                                     input logic ill);
    return {pc, adr, mw, ir, rw, rs, a, b, aop, im, ill};
  endfunction

  // Expected words per state, written out from the output table.
  function automatic logic [16:0] e_fetch(input logic mr);
    return mk(mr, 0, 0, mr, 0, 2'b10, 2'b00, 2'b10, 2'b00, imm, 0);
  endfunction
  function automatic logic [16:0] e_decode(input logic ill);
    return mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, imm, ill);
  endfunction
  function automatic logic [16:0] e_memadr();
    return mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, imm, 0);
  endfunction
  function automatic logic [16:0] e_memread();
    return mk(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, imm, 0);
  endfunction
  function automatic logic [16:0] e_memwb();
    return mk(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 2'b00, imm, 0);
  endfunction
  function automatic logic [16:0] e_memwrite();
    return mk(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, imm, 0);
  endfunction
  function automatic logic [16:0] e_execr();
    return mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, imm, 0);
  endfunction
  function automatic logic [16:0] e_execi();
    return mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b10, imm, 0);
  endfunction
  function automatic logic [16:0] e_aluwb();
    return mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, imm, 0);
  endfunction
  function automatic logic [16:0] e_branch(input logic pc);
    return mk(pc, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01, imm, 0);
  endfunction
  function automatic logic [16:0] e_jal();
    return mk(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00, imm, 0);
  endfunction

  task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic [1:0] im);
    bus.op     = o;
    bus.funct3 = f3;
    imm        = im;
  endtask

  // Called just after a rising edge: drive, compare at the falling edge, advance one cycle.
  task automatic cyc(input string tag, input logic mr, input logic z, input logic [16:0] exp);
    bus.MemReady = mr;
    bus.Zero     = z;
    @(negedge clk);
    chk(tag, obs, exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset        = 1'b0;
    bus.MemReady = 1'b1;
    bus.Zero     = 1'b0;
    set_instr(7'b0000000, 3'b000, 2'b00);
    #1 reset = 1'b1;
    #1 chk("reset outputs", obs, mk(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 0));
    @(posedge clk);
    #1 reset = 1'b0;

    // lw, no stalls: 5 cycles
    set_instr(7'b0000011, 3'b010, 2'b00);
    cyc("lw fetch",   1, 0, e_fetch(1));
    cyc("lw decode",  1, 0, e_decode(0));
    cyc("lw memadr",  1, 0, e_memadr());
    cyc("lw memread", 1, 0, e_memread());
    cyc("lw memwb",   1, 0, e_memwb());

    // lw with fetch and read stalls
    cyc("lw2 fetch stall", 0, 0, e_fetch(0));
    cyc("lw2 fetch",       1, 0, e_fetch(1));
    cyc("lw2 decode",      0, 0, e_decode(0));
    cyc("lw2 memadr",      0, 0, e_memadr());
    cyc("lw2 memread stall", 0, 0, e_memread());
    cyc("lw2 memread",     1, 0, e_memread());
    cyc("lw2 memwb",       1, 0, e_memwb());

    // sw, MemReady low for 3 cycles in MEMWRITE
    set_instr(7'b0100011, 3'b010, 2'b01);
    cyc("sw fetch",    1, 0, e_fetch(1));
    cyc("sw decode",   1, 0, e_decode(0));
    cyc("sw memadr",   1, 0, e_memadr());
    cyc("sw memwr 1",  0, 0, e_memwrite());
    cyc("sw memwr 2",  0, 0, e_memwrite());
    cyc("sw memwr 3",  0, 0, e_memwrite());
    cyc("sw memwr 4",  1, 0, e_memwrite());

    // R-type and I-type
    set_instr(7'b0110011, 3'b000, 2'b00);
    cyc("r fetch",  1, 0, e_fetch(1));
    cyc("r decode", 1, 0, e_decode(0));
    cyc("r exec",   1, 0, e_execr());
    cyc("r wb",     1, 0, e_aluwb());
    set_instr(7'b0010011, 3'b000, 2'b00);
    cyc("i fetch",  1, 0, e_fetch(1));
    cyc("i decode", 1, 0, e_decode(0));
    cyc("i exec",   1, 0, e_execi());
    cyc("i wb",     1, 0, e_aluwb());

    // beq taken / not taken, bne taken / not taken
    set_instr(7'b1100011, 3'b000, 2'b10);
    cyc("beq z1 fetch",  1, 1, e_fetch(1));
    cyc("beq z1 decode", 1, 1, e_decode(0));
    cyc("beq z1 branch", 1, 1, e_branch(1));
    cyc("beq z0 fetch",  1, 0, e_fetch(1));
    cyc("beq z0 decode", 1, 0, e_decode(0));
    cyc("beq z0 branch", 1, 0, e_branch(0));
    set_instr(7'b1100011, 3'b001, 2'b10);
    cyc("bne z0 fetch",  1, 0, e_fetch(1));
    cyc("bne z0 decode", 1, 0, e_decode(0));
    cyc("bne z0 branch", 1, 0, e_branch(1));
    cyc("bne z1 fetch",  1, 1, e_fetch(1));
    cyc("bne z1 decode", 1, 1, e_decode(0));
    cyc("bne z1 branch", 1, 1, e_branch(0));

    // jal
    set_instr(7'b1101111, 3'b000, 2'b11);
    cyc("jal fetch",  1, 0, e_fetch(1));
    cyc("jal decode", 1, 0, e_decode(0));
    cyc("jal jal",    1, 0, e_jal());
    cyc("jal wb",     1, 0, e_aluwb());

    // Illegal opcode, then illegal branch funct3
    set_instr(7'b1111111, 3'b000, 2'b00);
    cyc("ill op fetch",  1, 0, e_fetch(1));
    cyc("ill op decode", 1, 0, e_decode(1));
    cyc("ill op next",   0, 0, e_fetch(0));
    set_instr(7'b1100011, 3'b010, 2'b10);
    cyc("ill br fetch",  1, 0, e_fetch(1));
    cyc("ill br decode", 1, 0, e_decode(1));
    cyc("ill br next",   0, 0, e_fetch(0));

    // Asynchronous reset in the middle of MEMWRITE
    set_instr(7'b0100011, 3'b010, 2'b01);
    cyc("rst sw fetch",  1, 0, e_fetch(1));
    cyc("rst sw decode", 1, 0, e_decode(0));
    cyc("rst sw memadr", 1, 0, e_memadr());
    bus.MemReady = 1'b0;
    @(negedge clk);
    chk("rst sw memwr", obs, e_memwrite());
    #2 bus.MemReady = 1'b1;
    reset = 1'b1;
    #1 chk("rst async", obs, mk(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 2'b01, 0));
    @(posedge clk);
    #1 chk("rst held", obs, mk(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 2'b01, 0));
    reset = 1'b0;
    cyc("rst release mr0", 0, 0, e_fetch(0));
    cyc("rst release mr1", 1, 0, e_fetch(1));
    cyc("rst decode",      1, 0, e_decode(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
